// File: rtl/reg_word_serializer_if.sv
// reg_word_serializer_if: load strobe, parallel word and valid/ready beat stream of the serializer.
interface reg_word_serializer_if #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
);
    logic             ld;
    logic [WIDTH-1:0] in;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [CHUNK-1:0] out_data;
    logic             out_last;
    logic             done;

    modport master (
        output ld, in, out_ready,
        input  busy, out_valid, out_data, out_last, done
    );

    modport slave (
        input  ld, in, out_ready,
        output busy, out_valid, out_data, out_last, done
    );
endinterface

// File: rtl/reg_word_serializer.sv
// reg_word_serializer: captures a WIDTH-bit word on ld and streams it out LSB chunk first.
module reg_word_serializer #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic                clk,
    input logic                rst,
    reg_word_serializer_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state, state_d;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             done_q;
    logic             hs, last, cap;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_d;

    always_comb begin
        cap     = (state == IDLE) && bus.ld;
        hs      = (state == SEND) && bus.out_ready;
        last    = (cnt == LAST);
        state_d = cap ? SEND : (hs && last) ? IDLE : state;
    end

    // Counter returns to zero on the final beat so it never wraps past N-1 while sending.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sreg   <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= hs && last;
            if (cap) begin
                sreg <= bus.in;
                cnt  <= '0;
            end else if (hs) begin
                sreg <= (N > 1) ? (sreg >> CHUNK) : '0;
                cnt  <= last ? '0 : cnt + 1'b1;
            end
        end

    always_comb begin
        bus.busy      = (state == SEND);
        bus.out_valid = (state == SEND);
        bus.out_data  = (state == SEND) ? sreg[CHUNK-1:0] : '0;
        bus.out_last  = (state == SEND) && last;
        bus.done      = done_q;
    end
endmodule

// File: tb/tb_reg_word_serializer.sv
// tb_reg_word_serializer: directed checks of the 32/8 serializer and a 32/32 single-beat instance.
module tb_reg_word_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   hs_cnt;

    always #5 clk = ~clk;

    reg_word_serializer_if #(.WIDTH(32), .CHUNK(8))  a ();
    reg_word_serializer_if #(.WIDTH(32), .CHUNK(32)) b ();

    reg_word_serializer #(.WIDTH(32), .CHUNK(8))  dut_a (.clk(clk), .rst(rst), .bus(a));
    reg_word_serializer #(.WIDTH(32), .CHUNK(32)) dut_b (.clk(clk), .rst(rst), .bus(b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input string tag, input logic [7:0] d, input logic l);
        chk({tag, "_valid"}, 64'(a.out_valid), 64'(1'b1));
        chk({tag, "_data"}, 64'(a.out_data), 64'(d));
        chk({tag, "_last"}, 64'(a.out_last), 64'(l));
    endtask

    task automatic idle_a(input string tag, input logic d);
        chk({tag, "_valid"}, 64'(a.out_valid), 64'(1'b0));
        chk({tag, "_busy"}, 64'(a.busy), 64'(1'b0));
        chk({tag, "_data"}, 64'(a.out_data), 64'(8'h00));
        chk({tag, "_done"}, 64'(a.done), 64'(d));
    endtask

    logic [7:0]  t2_data [7] = '{8'hD4, 8'hC3, 8'hC3, 8'hC3, 8'hB2, 8'hA1, 8'hA1};
    logic        t2_last [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        t2_rdy  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0]  t3_data [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    logic [7:0]  t12_data[4] = '{8'h0C, 8'h00, 8'h00, 8'h00};
    logic [7:0]  t1_data [4] = '{8'h64, 8'h00, 8'h00, 8'h00};

    initial begin
        a.ld = 1'b0; a.in = '0; a.out_ready = 1'b0;
        b.ld = 1'b0; b.in = '0; b.out_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        idle_a("reset", 1'b0);
        chk("reset_last", 64'(a.out_last), 64'(1'b0));
        chk("reset_b_valid", 64'(b.out_valid), 64'(1'b0));
        @(negedge clk) rst = 1'b1;

        // T1
        a.in = 32'd100; a.ld = 1'b1; a.out_ready = 1'b1;
        tick();
        a.ld = 1'b0;
        chk("t1_busy", 64'(a.busy), 64'(1'b1));
        for (int i = 0; i < 4; i++) begin
            beat_a($sformatf("t1_b%0d", i), t1_data[i], i == 3);
            tick();
        end
        idle_a("t1_done", 1'b1);
        tick();
        idle_a("t1_after", 1'b0);

        // T2
        a.in = 32'hA1B2C3D4; a.ld = 1'b1;
        tick();
        a.ld = 1'b0;
        hs_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            a.out_ready = t2_rdy[i];
            beat_a($sformatf("t2_c%0d", i), t2_data[i], t2_last[i]);
            chk($sformatf("t2_done_c%0d", i), 64'(a.done), 64'(1'b0));
            if (a.out_valid && a.out_ready) hs_cnt++;
            tick();
        end
        chk("t2_handshakes", 64'(hs_cnt), 64'(4));
        idle_a("t2_done", 1'b1);
        a.out_ready = 1'b1;
        tick();
        idle_a("t2_after", 1'b0);

        // T3: ld held high during SEND, including the final handshake
        a.in = 32'h11223344; a.ld = 1'b1;
        tick();
        a.in = 32'd12;
        for (int i = 0; i < 4; i++) begin
            beat_a($sformatf("t3_b%0d", i), t3_data[i], i == 3);
            tick();
        end
        idle_a("t3_done", 1'b1);
        tick();
        a.ld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat_a($sformatf("t3_n%0d", i), t12_data[i], i == 3);
            tick();
        end
        idle_a("t3_ndone", 1'b1);
        tick();

        // T5: ld held continuously, back-to-back words with one IDLE cycle
        a.in = 32'h64; a.ld = 1'b1;
        tick();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 4; i++) begin
                beat_a($sformatf("t5_w%0d_b%0d", w, i), t1_data[i], i == 3);
                tick();
            end
            idle_a($sformatf("t5_w%0d_gap", w), 1'b1);
            tick();
        end
        a.ld = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        idle_a("t5_end", 1'b1);
        tick();

        // T4: asynchronous reset mid-word
        a.in = 32'hCAFEF00D; a.ld = 1'b1;
        tick();
        a.ld = 1'b0;
        beat_a("t4_b0", 8'h0D, 1'b0);
        tick();
        beat_a("t4_b1", 8'hF0, 1'b0);
        tick();
        beat_a("t4_b2", 8'hFE, 1'b0);
        #2 rst = 1'b0;
        #1;
        idle_a("t4_rst", 1'b0);
        chk("t4_rst_last", 64'(a.out_last), 64'(1'b0));
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_a($sformatf("t4_post%0d", i), 1'b0);
        end
        a.in = 32'h5; a.ld = 1'b1;
        tick();
        a.ld = 1'b0;
        beat_a("t4_new", 8'h05, 1'b0);

        // T6: single-beat configuration
        b.in = 32'hDEADBEEF; b.ld = 1'b1;
        tick();
        b.ld = 1'b0;
        chk("t6_valid", 64'(b.out_valid), 64'(1'b1));
        chk("t6_data", 64'(b.out_data), 64'(32'hDEADBEEF));
        chk("t6_last", 64'(b.out_last), 64'(1'b1));
        tick();
        chk("t6_done", 64'(b.done), 64'(1'b1));
        chk("t6_idle", 64'(b.out_valid), 64'(1'b0));
        chk("t6_idata", 64'(b.out_data), 64'(32'h0));
        tick();
        chk("t6_after", 64'(b.done), 64'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
